// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } arb_state_e;

  localparam logic        RW_READ             = 1'b1;
  localparam logic        RW_WRITE            = 1'b0;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;
  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned CNT_W               = 4;

  // Returns the winning requester index; on contention the one not served last wins.
  function automatic logic pick_grant(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled with directional modports.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              m0_req;
  logic              m0_rw;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_rw;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  m0_req, m0_rw, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_rw, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output mem_en, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment view: requesters plus memory model.
  modport master (
    output m0_req, m0_rw, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_rw, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  mem_en, mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that stops at zero; zero flag marks the final access cycle.
module arb_wait_counter
  import mem_arb_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting two requesters access to one memory port,
// with WAIT_CYCLES extra access cycles per transfer.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input logic           i_clk,
  input logic           i_rst_n,
  mem_arbiter_if.slave  io_bus
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(WAIT_CYCLES);

  arb_state_e        r_state;
  logic              r_gnt;
  logic              r_last;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_en;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_any_req;
  logic              w_gnt;
  logic              w_sel_rw;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

  assign w_any_req   = io_bus.m0_req | io_bus.m1_req;
  assign w_gnt       = pick_grant(io_bus.m0_req, io_bus.m1_req, r_last);
  assign w_sel_rw    = w_gnt ? io_bus.m1_rw    : io_bus.m0_rw;
  assign w_sel_addr  = w_gnt ? io_bus.m1_addr  : io_bus.m0_addr;
  assign w_sel_wdata = w_gnt ? io_bus.m1_wdata : io_bus.m0_wdata;

  assign w_cnt_load  = (r_state == StIdle) && w_any_req;
  assign w_cnt_dec   = (r_state == StAccess);

  arb_wait_counter u_wait_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (LoadVal),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_gnt       <= 1'b0;
      r_last      <= 1'b1;
      r_rw        <= RW_READ;
      r_addr      <= '0;
      r_mem_wdata <= '0;
      r_mem_en    <= 1'b0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_gnt       <= w_gnt;
            r_rw        <= w_sel_rw;
            r_addr      <= w_sel_addr;
            r_mem_wdata <= (w_sel_rw == RW_WRITE) ? w_sel_wdata : '0;
            r_mem_en    <= 1'b1;
            r_state     <= StAccess;
          end
        end
        StAccess: begin
          if (w_cnt_zero) begin
            r_mem_en <= 1'b0;
            if (r_rw == RW_READ) begin
              if (r_gnt) r_m1_rdata <= io_bus.mem_rdata;
              else       r_m0_rdata <= io_bus.mem_rdata;
            end
            if (r_gnt) r_m1_ack <= 1'b1;
            else       r_m0_ack <= 1'b1;
            r_state <= StResp;
          end
        end
        StResp: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_last   <= r_gnt;
          r_state  <= StIdle;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.mem_en    = r_mem_en;
  assign io_bus.mem_rw    = r_rw;
  assign io_bus.mem_addr  = r_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.m0_ack    = r_m0_ack;
  assign io_bus.m1_ack    = r_m1_ack;
  assign io_bus.m0_rdata  = r_m0_rdata;
  assign io_bus.m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table for single transfers plus hand-written
// contention, reset-abort, dropped-request and zero-wait sequences.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus  ();
  mem_arbiter_if bus0 ();

  mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  mem_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus0)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] GB = 32'h1111_1111;
  localparam logic [31:0] BB = 32'hBAD0_BAD0;
  localparam logic [31:0] CR = 32'hA5A5_0000;

  typedef struct {
    logic        m0_req, m0_rw;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_rw;
    logic [31:0] m1_addr, m1_wdata;
    logic [31:0] mem_rdata;
    logic        e_en, e_rw;
    logic [31:0] e_addr, e_wdata;
    logic        e_ack0, e_ack1;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(
    input logic m0r, input logic m0w, input logic [31:0] m0a, input logic [31:0] m0d,
    input logic m1r, input logic m1w, input logic [31:0] m1a, input logic [31:0] m1d,
    input logic [31:0] rd, input logic en, input logic rw, input logic [31:0] ad,
    input logic [31:0] wd, input logic a0, input logic a1,
    input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.m0_req = m0r; v.m0_rw = m0w; v.m0_addr = m0a; v.m0_wdata = m0d;
    v.m1_req = m1r; v.m1_rw = m1w; v.m1_addr = m1a; v.m1_wdata = m1d;
    v.mem_rdata = rd; v.e_en = en; v.e_rw = rw; v.e_addr = ad; v.e_wdata = wd;
    v.e_ack0 = a0; v.e_ack1 = a1; v.e_rd0 = r0; v.e_rd1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic which, input int budget, input string name);
    logic got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      got = which ? bus.m1_ack : bus.m0_ack;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".mem_en"},    32'(bus.mem_en),    32'd0);
    chk({tag, ".mem_rw"},    32'(bus.mem_rw),    32'd1);
    chk({tag, ".mem_addr"},  bus.mem_addr,       32'd0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata,      32'd0);
    chk({tag, ".m0_rdata"},  bus.m0_rdata,       32'd0);
    chk({tag, ".m1_rdata"},  bus.m1_rdata,       32'd0);
    chk({tag, ".m0_ack"},    32'(bus.m0_ack),    32'd0);
    chk({tag, ".m1_ack"},    32'(bus.m1_ack),    32'd0);
  endtask

  initial begin
    int         order[$];
    int         ack_cyc[$];
    logic [31:0] ack_addr[$];
    logic        any_ack;
    logic [4:0]  z_en;
    logic [4:0]  z_ack;

    rst_n = 1'b0;
    bus.m0_req = 1'b0; bus.m0_rw = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_rw = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.mem_rdata = '0;
    bus0.m0_req = 1'b0; bus0.m0_rw = 1'b0; bus0.m0_addr = '0; bus0.m0_wdata = '0;
    bus0.m1_req = 1'b0; bus0.m1_rw = 1'b0; bus0.m1_addr = '0; bus0.m1_wdata = '0;
    bus0.mem_rdata = '0;

    // m0 read of 0x10 (rdata valid only on final access cycle), then m1 write of 0x20.
    tv[0]  = mk(1'b1,1'b1,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0,     GB, 1'b1,1'b1,32'h10,32'h0,    1'b0,1'b0,32'h0,32'h0);
    tv[1]  = tv[0];
    tv[2]  = tv[0];
    tv[3]  = mk(1'b1,1'b1,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0,     DB, 1'b0,1'b1,32'h10,32'h0,    1'b1,1'b0,DB,32'h0);
    tv[4]  = mk(1'b0,1'b1,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0,     GB, 1'b0,1'b1,32'h10,32'h0,    1'b0,1'b0,DB,32'h0);
    tv[5]  = mk(1'b0,1'b1,32'h10,32'h0, 1'b1,1'b0,32'h20,32'h1234, GB, 1'b1,1'b0,32'h20,32'h1234, 1'b0,1'b0,DB,32'h0);
    tv[6]  = tv[5];
    tv[7]  = tv[5];
    tv[8]  = mk(1'b0,1'b1,32'h10,32'h0, 1'b1,1'b0,32'h20,32'h1234, BB, 1'b0,1'b0,32'h20,32'h1234, 1'b0,1'b1,DB,32'h0);
    tv[9]  = mk(1'b0,1'b1,32'h10,32'h0, 1'b0,1'b0,32'h20,32'h1234, BB, 1'b0,1'b0,32'h20,32'h1234, 1'b0,1'b0,DB,32'h0);
    tv[10] = tv[9];

    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      bus.m0_req = tv[i].m0_req; bus.m0_rw = tv[i].m0_rw;
      bus.m0_addr = tv[i].m0_addr; bus.m0_wdata = tv[i].m0_wdata;
      bus.m1_req = tv[i].m1_req; bus.m1_rw = tv[i].m1_rw;
      bus.m1_addr = tv[i].m1_addr; bus.m1_wdata = tv[i].m1_wdata;
      bus.mem_rdata = tv[i].mem_rdata;
      tick();
      chk($sformatf("v%0d.mem_en", i),    32'(bus.mem_en),   32'(tv[i].e_en));
      chk($sformatf("v%0d.mem_rw", i),    32'(bus.mem_rw),   32'(tv[i].e_rw));
      chk($sformatf("v%0d.mem_addr", i),  bus.mem_addr,      tv[i].e_addr);
      chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata,     tv[i].e_wdata);
      chk($sformatf("v%0d.m0_ack", i),    32'(bus.m0_ack),   32'(tv[i].e_ack0));
      chk($sformatf("v%0d.m1_ack", i),    32'(bus.m1_ack),   32'(tv[i].e_ack1));
      chk($sformatf("v%0d.m0_rdata", i),  bus.m0_rdata,      tv[i].e_rd0);
      chk($sformatf("v%0d.m1_rdata", i),  bus.m1_rdata,      tv[i].e_rd1);
    end

    // Both requesters held high: expect m0,m1,m0,m1 with acks WAIT+3 = 5 cycles apart.
    bus.m0_req = 1'b1; bus.m0_rw = 1'b1; bus.m0_addr = 32'h100;
    bus.m1_req = 1'b1; bus.m1_rw = 1'b1; bus.m1_addr = 32'h200;
    bus.mem_rdata = CR;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      tick();
      if (bus.m0_ack && bus.m1_ack) chk("contention.dual_ack", 32'd1, 32'd0);
      if (bus.m0_ack) begin order.push_back(0); ack_cyc.push_back(c); ack_addr.push_back(bus.mem_addr); end
      if (bus.m1_ack) begin order.push_back(1); ack_cyc.push_back(c); ack_addr.push_back(bus.mem_addr); end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    chk("contention.count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size(); k++) begin
      chk($sformatf("contention.grant%0d", k), 32'(order[k]), 32'(k % 2));
      chk($sformatf("contention.addr%0d", k), ack_addr[k], (k % 2 == 1) ? 32'h200 : 32'h100);
      if (k > 0) chk($sformatf("contention.gap%0d", k), 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd5);
    end
    chk("contention.m0_rdata", bus.m0_rdata, CR);
    chk("contention.m1_rdata", bus.m1_rdata, CR);
    repeat (2) tick();

    // m0 write alone so that m0 is the last-served requester before the reset test.
    bus.m0_req = 1'b1; bus.m0_rw = 1'b0; bus.m0_addr = 32'h70; bus.m0_wdata = 32'hCAFE;
    wait_ack(1'b0, 10, "presreset.m0_ack");
    bus.m0_req = 1'b0;
    repeat (2) tick();

    // Reset during ACCESS cycle 2: immediate reset values, no ack, m0 wins after release.
    bus.m0_req = 1'b1; bus.m0_rw = 1'b1; bus.m0_addr = 32'h30;
    tick();
    tick();
    chk("abort.pre_mem_en", 32'(bus.mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    bus.m1_req = 1'b1; bus.m1_rw = 1'b0; bus.m1_addr = 32'h40; bus.m1_wdata = 32'h9;
    any_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      any_ack = any_ack | bus.m0_ack | bus.m1_ack;
    end
    chk("abort.no_ack", 32'(any_ack), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("abort.regrant_en", 32'(bus.mem_en), 32'd1);
    chk("abort.regrant_addr", bus.mem_addr, 32'h30);
    wait_ack(1'b0, 10, "abort.m0_ack");
    bus.m0_req = 1'b0;
    wait_ack(1'b1, 12, "abort.m1_ack");
    chk("abort.m1_addr", bus.mem_addr, 32'h40);
    chk("abort.m1_wdata", bus.mem_wdata, 32'h9);
    bus.m1_req = 1'b0;
    repeat (2) tick();

    // m0 drops req and changes its inputs after grant; m1 arrives mid-ACCESS and waits.
    bus.m0_req = 1'b1; bus.m0_rw = 1'b0; bus.m0_addr = 32'h60; bus.m0_wdata = 32'h77;
    tick();
    bus.m0_req = 1'b0; bus.m0_rw = 1'b1; bus.m0_addr = 32'h99; bus.m0_wdata = 32'h55;
    bus.m1_req = 1'b1; bus.m1_rw = 1'b1; bus.m1_addr = 32'h80;
    tick();
    chk("drop.mem_addr", bus.mem_addr, 32'h60);
    chk("drop.mem_rw", 32'(bus.mem_rw), 32'd0);
    chk("drop.mem_wdata", bus.mem_wdata, 32'h77);
    wait_ack(1'b0, 10, "drop.m0_ack");
    wait_ack(1'b1, 12, "drop.m1_ack");
    chk("drop.m1_addr", bus.mem_addr, 32'h80);
    bus.m1_req = 1'b0;
    repeat (2) tick();

    // Zero-wait instance with req held: en,ack,idle repeating every 3 cycles.
    z_en  = 5'b01001;
    z_ack = 5'b10010;
    bus0.m0_req = 1'b1; bus0.m0_rw = 1'b1; bus0.m0_addr = 32'h50; bus0.mem_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("w0.c%0d.mem_en", i), 32'(bus0.mem_en), 32'(z_en[i]));
      chk($sformatf("w0.c%0d.m0_ack", i), 32'(bus0.m0_ack), 32'(z_ack[i]));
      if (i == 1) chk("w0.m0_rdata", bus0.m0_rdata, 32'h0BAD_F00D);
    end
    bus0.m0_req = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
